// File: rtl/deser_pkg.sv
// Shared types and constants for the 16-bit serial word assembler.
// Slot ordering matches the 16:1 bit-select mux (slot 0 is bit 15).
package deser_pkg;

    localparam int unsigned W     = 16;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PEND = 1'b1
    } fill_state_t;

    function automatic logic [SEL_W-1:0] slot_to_bit(input logic [SEL_W-1:0] s);
        return SEL_W'(W - 1) - s;
    endfunction

endpackage

// File: rtl/demux1_16.sv
// Combinational 4-to-16 one-hot slot decoder, gated by an enable.
// Uses the mux ordering: sel 0 drives bit 15, sel 15 drives bit 0.
module demux1_16
    import deser_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [W-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        onehot[slot_to_bit(sel)] = en;
    end

endmodule

// File: rtl/deser16_demux.sv
// Serial-to-parallel word assembler with a shadow word and a registered output
// word under valid/ready backpressure.
module deser16_demux
    import deser_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             flush,
    output logic [SEL_W-1:0] slot,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    input  logic             dout_ready
);

    fill_state_t      state_q, state_d;
    logic [SEL_W-1:0] slot_q, slot_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]     dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    logic             accept;
    logic             write_en;
    logic             complete;
    logic             can_load;
    logic             load;
    logic [W-1:0]     bit_we;
    logic [W-1:0]     shadow_wr;

    // Flush wins over an accept in the same cycle: the presented bit is dropped.
    assign accept   = din_valid & din_ready;
    assign write_en = accept & ~flush;
    assign complete = write_en & (slot_q == SEL_W'(W - 1));
    assign can_load = ~dout_valid_q | dout_ready;
    assign load     = (complete | (state_q == PEND)) & can_load & ~flush;

    demux1_16 u_demux (
        .sel    (slot_q),
        .en     (write_en),
        .onehot (bit_we)
    );

    // Shadow word including the bit being accepted this cycle.
    assign shadow_wr = (shadow_q & ~bit_we) | (bit_we & {W{din}});

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FILL;
        end else if (load) begin
            state_d = FILL;
        end else if (complete) begin
            state_d = PEND;
        end
    end

    // FSM outputs
    always_comb begin
        din_ready = 1'b0;
        if (!rst && state_q == FILL) begin
            din_ready = 1'b1;
        end
    end

    // Datapath next state
    always_comb begin
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;

        if (flush) begin
            slot_d   = '0;
            shadow_d = '0;
        end else if (write_en) begin
            slot_d   = slot_q + SEL_W'(1);
            shadow_d = shadow_wr;
        end

        if (load) begin
            dout_d       = shadow_wr;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign slot       = slot_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule
